// File: rtl/lcd_bl_pkg.sv
// Backlight fader shared definitions.
// Register map, bit positions and fade FSM states.
package lcd_bl_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_TARGET   = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FADE_EN = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY = 8;
  localparam int STAT_DONE = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN
  } fade_state_t;

endpackage

// File: rtl/lcd_bl_pwm_core.sv
// Prescaler, PWM counter and duty compare.
// New duty is taken only at a period boundary.
module lcd_bl_pwm_core #(
  parameter int DUTY_W = 8,
  parameter int PRE_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              pre_restart,
  input  logic [PRE_W-1:0]  prescale,
  input  logic [DUTY_W-1:0] duty_next,
  output logic              period_end,
  output logic              pwm_out
);

  logic [PRE_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] active;
  logic              tick;

  assign tick       = en && (pre_cnt == prescale);
  assign period_end = tick && (cnt == '1);
  assign pwm_out    = en && (cnt < active);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
      active  <= '0;
    end else begin
      if (!en || pre_restart || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + 1'b1;
      if (!en)
        cnt <= '0;
      else if (tick)
        cnt <= cnt + 1'b1;
      if (period_end)
        active <= duty_next;
    end
  end

endmodule

// File: rtl/lcd_backlight_fader.sv
// Avalon-MM backlight fader: registers, fade FSM, irq.
// PWM generation lives in lcd_bl_pwm_core.
module lcd_backlight_fader
  import lcd_bl_pkg::*;
#(
  parameter int DUTY_W = 8,
  parameter int PRE_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pwm_out,
  output logic        irq
);

  logic              ctrl_en;
  logic              ctrl_fade;
  logic              ctrl_irq_en;
  logic [DUTY_W-1:0] target;
  logic [PRE_W-1:0]  prescale;
  logic [DUTY_W-1:0] current;
  logic [DUTY_W-1:0] cur_nxt;
  fade_state_t       state;
  fade_state_t       st_nxt;
  logic              step;
  logic              done;
  logic              done_set;
  logic              done_clr;
  logic              period_end;
  logic              wr;
  logic              wr_ctrl;
  logic              wr_target;
  logic              wr_pre;
  logic              wr_status;
  logic              unused_wdata;

  assign wr        = chipselect && !write_n;
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_target = wr && (address == ADDR_TARGET);
  assign wr_pre    = wr && (address == ADDR_PRESCALE);
  assign wr_status = wr && (address == ADDR_STATUS);

  assign unused_wdata = ^writedata;

  always_comb begin
    cur_nxt = current;
    st_nxt  = ST_IDLE;
    step    = 1'b0;
    unique case (1'b1)
      !ctrl_fade:
        cur_nxt = target;
      ctrl_fade && (current < target): begin
        cur_nxt = current + 1'b1;
        st_nxt  = ST_UP;
        step    = 1'b1;
      end
      ctrl_fade && (current > target): begin
        cur_nxt = current - 1'b1;
        st_nxt  = ST_DOWN;
        step    = 1'b1;
      end
      default: ;
    endcase
    // Landing on the target ends the fade on this boundary.
    if (cur_nxt == target)
      st_nxt = ST_IDLE;
  end

  assign done_set = period_end && (st_nxt == ST_IDLE)
                    && ((state != ST_IDLE) || step);
  assign done_clr = wr_status && writedata[STAT_DONE];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_fade   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      target      <= '0;
      prescale    <= '0;
      current     <= '0;
      state       <= ST_IDLE;
      done        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= writedata[CTRL_EN];
        ctrl_fade   <= writedata[CTRL_FADE_EN];
        ctrl_irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (wr_target)
        target <= writedata[DUTY_W-1:0];
      if (wr_pre)
        prescale <= writedata[PRE_W-1:0];
      if (period_end) begin
        current <= cur_nxt;
        state   <= st_nxt;
      end
      if (done_set)
        done <= 1'b1;
      else if (done_clr)
        done <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN]      = ctrl_en;
        readdata[CTRL_FADE_EN] = ctrl_fade;
        readdata[CTRL_IRQ_EN]  = ctrl_irq_en;
      end
      ADDR_TARGET:
        readdata[DUTY_W-1:0] = target;
      ADDR_PRESCALE:
        readdata[PRE_W-1:0] = prescale;
      ADDR_STATUS: begin
        readdata[DUTY_W-1:0] = current;
        readdata[STAT_BUSY]  = (state != ST_IDLE);
        readdata[STAT_DONE]  = done;
      end
      default: ;
    endcase
  end

  assign irq = done && ctrl_irq_en;

  lcd_bl_pwm_core #(
    .DUTY_W (DUTY_W),
    .PRE_W  (PRE_W)
  ) u_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (ctrl_en),
    .pre_restart (wr_pre),
    .prescale    (prescale),
    .duty_next   (cur_nxt),
    .period_end  (period_end),
    .pwm_out     (pwm_out)
  );

endmodule

// File: tb/tb_lcd_backlight_fader.sv
// Scoreboard bench for lcd_backlight_fader.
// Stimulus queues expectations; a monitor pops and compares.
module tb_lcd_backlight_fader;

  localparam int K_RD   = 0;
  localparam int K_PWM  = 1;
  localparam int K_IRQ  = 2;
  localparam int K_MEAS = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        pwm_out;
  logic        irq;

  exp_t        sb[$];
  logic        chk_req = 1'b0;
  int          meas = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  lcd_backlight_fader #(
    .DUTY_W (8),
    .PRE_W  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out),
    .irq        (irq)
  );

  always @(negedge clk) begin
    if (chk_req) begin
      exp_t        e;
      logic [31:0] act;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: no expectation queued");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_RD:    act = readdata;
          K_PWM:   act = {31'b0, pwm_out};
          K_IRQ:   act = {31'b0, irq};
          default: act = meas;
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h",
                   e.name, act, e.exp);
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic expect_q(input string nm, input int kind,
                          input logic [31:0] exp);
    exp_t e;
    e.name = nm;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a,
                        input logic [31:0] exp);
    #1;
    address = a;
    expect_q(nm, K_RD, exp);
  endtask

  task automatic sig_chk(input string nm, input int kind,
                         input logic [31:0] exp);
    #1;
    expect_q(nm, kind, exp);
  endtask

  task automatic measure(input int n);
    meas = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) meas++;
    end
  endtask

  task automatic wait_change(input logic [7:0] old, input int bound,
                             input string nm);
    bit hit = 0;
    address = 2'd3;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (readdata[7:0] != old) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, duty stuck at %0d", nm, old);
    end
  endtask

  task automatic wait_val(input logic [7:0] v, input int bound,
                          input string nm);
    bit hit = 0;
    address = 2'd3;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (readdata[7:0] == v) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, duty %0d never %0d",
               nm, readdata[7:0], v);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_target", 2'd1, 32'h0);
    rd_chk("rst_pre", 2'd2, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h0);
    sig_chk("rst_pwm", K_PWM, 32'h0);
    sig_chk("rst_irq", K_IRQ, 32'h0);

    wr(2'd2, 32'hABCD_1234);
    rd_chk("pre_mask", 2'd2, 32'h0000_1234);
    wr(2'd1, 32'h0000_01FF);
    rd_chk("target_mask", 2'd1, 32'h0000_00FF);
    wr(2'd0, 32'hFFFF_FFF6);
    rd_chk("ctrl_mask", 2'd0, 32'h0000_0006);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h0);

    wr(2'd1, 32'd64);
    wr(2'd0, 32'h1);
    measure(200);
    sig_chk("pre_boundary", K_MEAS, 32'd0);
    repeat (100) @(negedge clk);
    measure(256);
    sig_chk("duty64", K_MEAS, 32'd64);
    rd_chk("status64", 2'd3, 32'h0000_0040);

    wr(2'd1, 32'd0);
    repeat (300) @(negedge clk);
    measure(256);
    sig_chk("duty0", K_MEAS, 32'd0);
    wr(2'd1, 32'd255);
    repeat (300) @(negedge clk);
    measure(256);
    sig_chk("duty255", K_MEAS, 32'd255);
    rd_chk("status255", 2'd3, 32'h0000_00FF);

    wr(2'd0, 32'h0);
    measure(256);
    sig_chk("en_off_pwm", K_MEAS, 32'd0);
    rd_chk("en_off_keep", 2'd3, 32'h0000_00FF);

    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    repeat (300) @(negedge clk);
    rd_chk("back_to0", 2'd3, 32'h0);

    wr(2'd0, 32'h7);
    wr(2'd1, 32'd3);
    wait_change(8'd0, 300, "fade_1");
    rd_chk("fade_1", 2'd3, 32'h0000_0101);
    wait_change(8'd1, 300, "fade_2");
    rd_chk("fade_2", 2'd3, 32'h0000_0102);
    wait_change(8'd2, 300, "fade_3");
    rd_chk("fade_3_done", 2'd3, 32'h0000_0203);
    sig_chk("fade_irq", K_IRQ, 32'h1);

    wr(2'd3, 32'h200);
    rd_chk("done_clr", 2'd3, 32'h0000_0003);
    sig_chk("irq_clr", K_IRQ, 32'h0);

    wr(2'd1, 32'd5);
    wait_change(8'd3, 300, "fade_4");
    repeat (255) @(posedge clk);
    #1;
    wr(2'd3, 32'h200);
    rd_chk("set_wins", 2'd3, 32'h0000_0205);
    sig_chk("set_wins_irq", K_IRQ, 32'h1);
    wr(2'd3, 32'h200);
    rd_chk("later_clr", 2'd3, 32'h0000_0005);
    sig_chk("later_clr_irq", K_IRQ, 32'h0);

    wr(2'd1, 32'd20);
    wait_val(8'd10, 2000, "up_to10");
    wr(2'd1, 32'd5);
    wait_change(8'd10, 300, "reverse");
    rd_chk("reverse_9", 2'd3, 32'h0000_0109);
    wait_val(8'd5, 2000, "down_to5");
    rd_chk("down_done", 2'd3, 32'h0000_0205);
    sig_chk("down_irq", K_IRQ, 32'h1);
    wr(2'd3, 32'h200);

    wr(2'd0, 32'h1);
    wr(2'd1, 32'd64);
    wr(2'd2, 32'd3);
    repeat (1100) @(negedge clk);
    measure(1024);
    sig_chk("pre3_duty64", K_MEAS, 32'd256);
    rd_chk("pre3_status", 2'd3, 32'h0000_0040);

    wr(2'd2, 32'd0);
    wr(2'd0, 32'h7);
    wr(2'd1, 32'd200);
    wait_change(8'd64, 1200, "pre_rst");
    rd_chk("pre_rst_busy", 2'd3, 32'h0000_0141);
    #1 reset_n = 1'b0;
    @(posedge clk);
    rd_chk("in_rst_status", 2'd3, 32'h0);
    #1 reset_n = 1'b1;
    sig_chk("post_rst_pwm", K_PWM, 32'h0);
    sig_chk("post_rst_irq", K_IRQ, 32'h0);
    rd_chk("post_rst_ctrl", 2'd0, 32'h0);
    rd_chk("post_rst_tgt", 2'd1, 32'h0);
    rd_chk("post_rst_pre", 2'd2, 32'h0);
    rd_chk("post_rst_stat", 2'd3, 32'h0);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_backlight_fader.md
LCD_BACKLIGHT_FADER -- requirements
Module: lcd_backlight_fader

Interface
REQ-001 Parameter DUTY_W, default 8, duty and PWM counter width.
REQ-002 Parameter PRE_W, default 16, prescaler register width.
REQ-003 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 Port reset_n, input, 1, reset; synchronous and active-low.
REQ-005 Port address, input, 2, Avalon-MM slave word address.
REQ-006 Port chipselect, input, 1, slave select.
REQ-007 Port write_n, input, 1, active-low write strobe.
REQ-008 Port writedata, input, 32, write data.
REQ-009 Port readdata, output, 32, read data; combinational; zero wait states.
REQ-010 Port pwm_out, output, 1, backlight PWM drive.
REQ-011 Port irq, output, 1, fade-done interrupt; level-sensitive.

Function
REQ-012 Register map SHALL be as follows; unused bits SHALL read 0:
- Address 0 CTRL (rw): bit0 EN, bit1 FADE_EN, bit2 IRQ_EN.
- Address 1 TARGET (rw): bits [DUTY_W-1:0].
- Address 2 PRESCALE (rw): bits [PRE_W-1:0].
- Address 3 STATUS: bits [7:0] current duty (ro), bit8 BUSY (ro), bit9 DONE (write-1-to-clear).
REQ-013 A write SHALL occur when chipselect=1 and write_n=0; the register SHALL update on the same clock edge.
REQ-014 readdata SHALL be the addressed register, zero-extended, with no latency; it SHALL be independent of chipselect.
REQ-015 Prescaler: a tick SHALL occur once every PRESCALE+1 clk cycles; PRESCALE=0 SHALL give a tick every cycle.
REQ-016 PWM counter SHALL increment on each tick and wrap from 2^DUTY_W-1 to 0; a period boundary is a tick with counter = max.
REQ-017 pwm_out SHALL be 1 iff EN=1 and counter < active duty; duty 0 SHALL give constant 0; duty 255 SHALL give 255/256 high.
REQ-018 Active duty SHALL change only at a period boundary, so no pulse is truncated or extended.
REQ-019 FSM states SHALL be IDLE, UP and DOWN, evaluated at each period boundary:
- FADE_EN=0: current duty := TARGET; next state IDLE.
- FADE_EN=1 and current < TARGET: current +1; state UP.
- FADE_EN=1 and current > TARGET: current -1; state DOWN.
- Equal: state IDLE.
REQ-020 DONE SHALL be set when the FSM moves from UP or DOWN to IDLE; if set and clear occur in the same cycle, set SHALL win.
REQ-021 BUSY SHALL be 1 when state is not IDLE.
REQ-022 A TARGET write mid-fade SHALL re-evaluate direction at the next boundary; no reset of the counter is required.
REQ-023 EN=0: prescaler and counter SHALL be held at 0; pwm_out=0; FSM frozen; current duty retained.
REQ-024 A PRESCALE write SHALL restart the prescaler count at 0.
REQ-025 irq SHALL equal DONE and IRQ_EN.

Reset
REQ-026 On reset_n=0 at a clk edge, all registers, the counter, prescaler, current and active duty, and DONE SHALL be 0, and the FSM SHALL be IDLE.
REQ-027 During reset and on the first cycle after it, pwm_out=0, irq=0 and readdata=0 for all addresses.
REQ-028 Reset mid-fade SHALL abort the fade without setting DONE.

Structure
REQ-029 Package lcd_bl_pkg SHALL hold the register address constants, CTRL/STATUS bit positions and the FSM state enum.
REQ-030 Sub-module lcd_bl_pwm_core SHALL contain the prescaler, counter and compare, and SHALL output period_end.
REQ-031 The top level SHALL contain the register file, FSM and irq logic.

Verification
REQ-032 PRESCALE=0, FADE_EN=0, TARGET=64, EN=1 -> from the first boundary, pwm_out is high 64 of every 256 clks.
REQ-033 TARGET=0 -> pwm_out constant 0; TARGET=255 -> exactly one low clk per 256.
REQ-034 FADE_EN=1, current=0, TARGET=3 -> duty 1, 2, 3 on successive periods; BUSY=1 until duty 3; DONE=1 and irq=1 (IRQ_EN=1) after the 3rd boundary.
REQ-035 Mid-fade UP at duty 10, write TARGET=5 -> next boundary duty 9 in state DOWN; DONE after duty reaches 5.
REQ-036 Write STATUS bit9=1 on the cycle DONE sets -> DONE stays 1; a later write-1 -> DONE=0, irq=0.
REQ-037 PRESCALE=3 -> period is 1024 clks; reset_n=0 mid-fade -> next cycle all reads 0 and pwm_out=0.
